// File: rtl/indicator_arbiter.sv
// Shares three indicator LEDs among three requesters with a minimum hold window and a dark gap on handover.
// Optional feature: define INDICATOR_RR_EN for round-robin arbitration (default build is fixed priority).
module indicator_arbiter #(
    parameter int HOLD_BITS = 20,
    parameter int GAP_BITS  = 18
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    input  logic [2:0] pat0,
    input  logic [2:0] pat1,
    input  logic [2:0] pat2,
    output logic [2:0] grant,
    output logic [2:0] led_out,
    output logic       busy,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [HOLD_BITS-1:0] HOLD_LOAD = '1;
    localparam logic [HOLD_BITS-1:0] GAP_LOAD  = HOLD_BITS'((64'd1 << GAP_BITS) - 64'd1);

    state_t               state_q, state_d;
    logic [HOLD_BITS-1:0] cnt_q, cnt_d;
    logic [2:0]           grant_q, grant_d;
    logic [2:0]           led_q, led_d;
    logic [1:0]           win_idx;
    logic [1:0]           own_idx;
    logic [2:0]           win_oh;
    logic [2:0]           pat_win;
    logic [2:0]           pat_own;

`ifdef INDICATOR_RR_EN
    logic [1:0] ptr_q, ptr_d;

    // Search starts just after the last granted index, so the previous owner is considered last.
    always_comb begin
        win_idx = 2'd0;
        case (ptr_q)
            2'd0:    win_idx = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
            2'd1:    win_idx = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
            default: win_idx = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
        endcase
    end

    always_comb begin
        ptr_d = ptr_q;
        case (grant_d)
            3'b001:  ptr_d = 2'd0;
            3'b010:  ptr_d = 2'd1;
            3'b100:  ptr_d = 2'd2;
            default: ptr_d = ptr_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= 2'd2;
        else     ptr_q <= ptr_d;
    end
`else
    always_comb begin
        win_idx = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
    end
`endif

    always_comb begin
        own_idx = grant_q[1] ? 2'd1 : (grant_q[2] ? 2'd2 : 2'd0);
        win_oh  = 3'b001 << win_idx;
        case (win_idx)
            2'd0:    pat_win = pat0;
            2'd1:    pat_win = pat1;
            default: pat_win = pat2;
        endcase
        case (own_idx)
            2'd0:    pat_own = pat0;
            2'd1:    pat_own = pat1;
            default: pat_own = pat2;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        led_d   = led_q;
        case (state_q)
            IDLE: begin
                if (req != 3'b000) begin
                    state_d = HOLD;
                    grant_d = win_oh;
                    led_d   = pat_win;
                    cnt_d   = HOLD_LOAD;
                end
            end
            HOLD: begin
                cnt_d = cnt_q - HOLD_BITS'(1);
                led_d = pat_own;
                if (cnt_q == '0) begin
                    if (req != 3'b000 && win_oh == grant_q) begin
                        cnt_d = HOLD_LOAD;
                    end else if (req == 3'b000) begin
                        state_d = IDLE;
                        grant_d = 3'b000;
                        led_d   = 3'b000;
                        cnt_d   = '0;
                    end else begin
                        state_d = GAP;
                        grant_d = 3'b000;
                        led_d   = 3'b000;
                        cnt_d   = GAP_LOAD;
                    end
                end
            end
            GAP: begin
                cnt_d   = cnt_q - HOLD_BITS'(1);
                grant_d = 3'b000;
                led_d   = 3'b000;
                if (cnt_q == '0) begin
                    if (req != 3'b000) begin
                        state_d = HOLD;
                        grant_d = win_oh;
                        led_d   = pat_win;
                        cnt_d   = HOLD_LOAD;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 3'b000;
                led_d   = 3'b000;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            grant_q <= 3'b000;
            led_q   <= 3'b000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            led_q   <= led_d;
        end
    end

    assign grant     = grant_q;
    assign led_out   = led_q;
    assign busy      = (state_q != IDLE);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_indicator_arbiter.sv
// Directed bench for indicator_arbiter with a cycle-count model of owner/phase, checked every negedge.
// Build with or without INDICATOR_RR_EN; expectations follow the selected arbitration mode.
module tb_indicator_arbiter;

    localparam int HB       = 4;
    localparam int GB       = 2;
    localparam int HOLD_LEN = 1 << HB;
    localparam int GAP_LEN  = 1 << GB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] req = 3'b000;
    logic [2:0] pat0 = 3'b000;
    logic [2:0] pat1 = 3'b000;
    logic [2:0] pat2 = 3'b000;
    logic [2:0] grant;
    logic [2:0] led_out;
    logic       busy;
    logic [1:0] state_dbg;

    int checks = 0;
    int errors = 0;

    indicator_arbiter #(.HOLD_BITS(HB), .GAP_BITS(GB)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .pat0     (pat0),
        .pat1     (pat1),
        .pat2     (pat2),
        .grant    (grant),
        .led_out  (led_out),
        .busy     (busy),
        .state_dbg(state_dbg)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    // Model: phase 0 idle, 1 hold, 2 gap; m_left = visible cycles remaining in the phase.
    int         m_phase, m_owner, m_left, m_ptr;
    logic [2:0] m_led;

    function automatic int pick(input logic [2:0] r, input int ptr);
`ifdef INDICATOR_RR_EN
        for (int k = 1; k <= 3; k++) begin
            int j;
            j = (ptr + k) % 3;
            if (r[j]) return j;
        end
`else
        for (int j = 0; j < 3; j++) if (r[j]) return j;
`endif
        return -1;
    endfunction

    function automatic logic [2:0] pat_of(input int idx, input logic [2:0] p0,
                                          input logic [2:0] p1, input logic [2:0] p2);
        if (idx == 0) return p0;
        if (idx == 1) return p1;
        return p2;
    endfunction

    always @(posedge clk or posedge rst) begin : model
        int w, ph, own, left, ptr;
        logic [2:0] led;
        if (rst) begin
            m_phase <= 0;
            m_owner <= -1;
            m_left  <= 0;
            m_ptr   <= 2;
            m_led   <= 3'b000;
        end else begin
            w = pick(req, m_ptr);
            ph = m_phase; own = m_owner; left = m_left; ptr = m_ptr; led = m_led;
            if (m_phase == 0) begin
                if (w >= 0) begin
                    ph = 1; own = w; left = HOLD_LEN; ptr = w; led = pat_of(w, pat0, pat1, pat2);
                end
            end else if (m_phase == 1) begin
                if (m_left > 1) begin
                    left = m_left - 1; led = pat_of(own, pat0, pat1, pat2);
                end else if (w == own) begin
                    left = HOLD_LEN; led = pat_of(own, pat0, pat1, pat2);
                end else if (w < 0) begin
                    ph = 0; own = -1; led = 3'b000;
                end else begin
                    ph = 2; own = -1; left = GAP_LEN; led = 3'b000;
                end
            end else begin
                if (m_left > 1) begin
                    left = m_left - 1;
                end else if (w >= 0) begin
                    ph = 1; own = w; left = HOLD_LEN; ptr = w; led = pat_of(w, pat0, pat1, pat2);
                end else begin
                    ph = 0;
                end
            end
            m_phase <= ph;
            m_owner <= own;
            m_left  <= left;
            m_ptr   <= ptr;
            m_led   <= led;
        end
    end

    // compare process
    always @(negedge clk) begin : compare
        logic [2:0] eg;
        if (!rst) begin
            eg = (m_phase == 1) ? 3'(1 << m_owner) : 3'b000;
            chk("model_grant", 32'(grant), 32'(eg));
            chk("model_led", 32'(led_out), 32'(m_led));
            chk("model_busy", 32'(busy), 32'(m_phase != 0));
        end
    end

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(busy), 32'd0);
    endtask

    logic [2:0] exp_g;

    initial begin
        // reset and idle
        @(negedge clk);
        @(negedge clk);
        chk("reset_grant", 32'(grant), 32'd0);
        chk("reset_led", 32'(led_out), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        #1 rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_grant", 32'(grant), 32'd0);
        end

        // single owner
        #1 pat0 = 3'b101; req = 3'b001;
        @(negedge clk);
        chk("single_grant", 32'(grant), 32'b001);
        chk("single_led", 32'(led_out), 32'b101);
        chk("single_busy", 32'(busy), 32'd1);
        @(negedge clk);
        @(negedge clk);
        #1 pat0 = 3'b010;
        @(negedge clk);
        chk("pat_latency", 32'(led_out), 32'b010);
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            chk("single_continuous", 32'(grant), 32'b001);
        end
        #1 req = 3'b000;
        wait_idle("single_release_idle");

        // priority, no preemption
        #1 pat1 = 3'b110; req = 3'b110;
        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
`ifdef INDICATOR_RR_EN
            exp_g = (i < 16) ? 3'b010 : (i < 20) ? 3'b000 : 3'b100;
`else
            exp_g = (i < 16) ? 3'b010 : (i < 20) ? 3'b000 : 3'b001;
`endif
            chk("prio_grant", 32'(grant), 32'(exp_g));
            if (i >= 16 && i < 20) chk("prio_gap_led", 32'(led_out), 32'd0);
            if (i == 4) #1 req = 3'b111;
        end
        #1 req = 3'b000;
        wait_idle("prio_release_idle");

        // owner release
        #1 pat2 = 3'b011; req = 3'b100;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            if (i < 16) begin
                chk("release_grant", 32'(grant), 32'b100);
                chk("release_led", 32'(led_out), 32'b011);
            end else begin
                chk("release_end_grant", 32'(grant), 32'd0);
                chk("release_end_led", 32'(led_out), 32'd0);
                chk("release_end_busy", 32'(busy), 32'd0);
            end
            if (i == 2) #1 req = 3'b000;
        end

        // arbitration mode with all requesting
        #1 pat0 = 3'b101; req = 3'b111;
        for (int i = 0; i < 76; i++) begin
            @(negedge clk);
`ifdef INDICATOR_RR_EN
            exp_g = ((i % 20) < 16) ? 3'(1 << ((i / 20) % 3)) : 3'b000;
`else
            exp_g = 3'b001;
`endif
            chk("arb_grant", 32'(grant), 32'(exp_g));
        end
        #1 req = 3'b000;
        wait_idle("arb_release_idle");

        // async reset mid-hold
        #1 pat0 = 3'b101; req = 3'b001;
        for (int i = 0; i < 7; i++) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("async_grant", 32'(grant), 32'd0);
        chk("async_led", 32'(led_out), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("regrant_grant", 32'(grant), 32'b001);
        chk("regrant_led", 32'(led_out), 32'b101);
        chk("regrant_busy", 32'(busy), 32'd1);
        #1 req = 3'b000;
        wait_idle("final_idle");

        // final report
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
